// File: rtl/cb_output_packer.sv
// rtl/cb_output_packer.sv - packs serial code-block bits MSB-first into bytes
// behind a small word FIFO, with per-block bit/filler/CRC statistics.
module cb_output_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        bit_in_i,
    input  logic        bit_valid_i,
    input  logic        start_i,
    input  logic        filling_i,
    input  logic        crc_i,
    input  logic        stop_i,
    input  logic        block_size_i,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic        out_valid_o,
    output logic        out_sop_o,
    output logic        out_eop_o,
    output logic        out_size_o,
    output logic [15:0] blk_bits_o,
    output logic [15:0] blk_fill_o,
    output logic [15:0] blk_crc_o,
    output logic        blk_done_o,
    output logic        overflow_o,
    output logic        proto_err_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        sop_arm_q, sop_arm_d;
    logic        size_q, size_d;
    logic [15:0] cnt_bits_q, cnt_bits_d;
    logic [15:0] cnt_fill_q, cnt_fill_d;
    logic [15:0] cnt_crc_q, cnt_crc_d;
    logic [15:0] blk_bits_q, blk_bits_d;
    logic [15:0] blk_fill_q, blk_fill_d;
    logic [15:0] blk_crc_q, blk_crc_d;
    logic        blk_done_q, blk_done_d;
    logic        ovf_q, ovf_d;
    logic        perr_q, perr_d;

    logic        wr_en;
    logic [9:0]  wr_word;
    logic        restart;
    logic        finish;
    logic [7:0]  new_sr;
    logic [3:0]  pad_shamt;

    logic [9:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        push;
    logic [9:0]  head;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign new_sr    = {sr_q[6:0], bit_in_i & ~filling_i};
    assign pad_shamt = 4'd8 - {1'b0, idx_q};

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sop_arm_d  = sop_arm_q;
        size_d     = size_q;
        cnt_bits_d = cnt_bits_q;
        cnt_fill_d = cnt_fill_q;
        cnt_crc_d  = cnt_crc_q;
        blk_bits_d = blk_bits_q;
        blk_fill_d = blk_fill_q;
        blk_crc_d  = blk_crc_q;
        blk_done_d = 1'b0;
        perr_d     = perr_q;
        wr_en      = 1'b0;
        wr_word    = '0;
        restart    = 1'b0;
        finish     = 1'b0;

        case (state_q)
            S_IDLE: begin
                restart = start_i;
            end
            S_COLLECT: begin
                if (start_i) begin
                    perr_d  = 1'b1;
                    restart = 1'b1;
                end else if (stop_i) begin
                    state_d = S_FLUSH;
                    if (bit_valid_i) perr_d = 1'b1;
                end else if (bit_valid_i) begin
                    cnt_bits_d = sat_inc(cnt_bits_q);
                    if (filling_i) cnt_fill_d = sat_inc(cnt_fill_q);
                    if (crc_i) cnt_crc_d = sat_inc(cnt_crc_q);
                    if (idx_q == 3'd7) begin
                        // A completed byte waits in pend until we know whether it is the last.
                        pend_d     = new_sr;
                        pend_vld_d = 1'b1;
                        sr_d       = '0;
                        idx_d      = 3'd0;
                        if (pend_vld_q) begin
                            wr_en     = 1'b1;
                            wr_word   = {sop_arm_q, 1'b0, pend_q};
                            sop_arm_d = 1'b0;
                        end
                    end else begin
                        sr_d  = new_sr;
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_FLUSH: begin
                if (start_i) begin
                    perr_d  = 1'b1;
                    restart = 1'b1;
                end else if (pend_vld_q) begin
                    wr_en      = 1'b1;
                    wr_word    = {sop_arm_q, idx_q == 3'd0, pend_q};
                    sop_arm_d  = 1'b0;
                    pend_vld_d = 1'b0;
                    finish     = (idx_q == 3'd0);
                end else begin
                    if (idx_q != 3'd0) begin
                        wr_en     = 1'b1;
                        wr_word   = {sop_arm_q, 1'b1, sr_q << pad_shamt};
                        sop_arm_d = 1'b0;
                    end
                    finish = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (restart) begin
            state_d    = S_COLLECT;
            size_d     = block_size_i;
            sr_d       = '0;
            idx_d      = 3'd0;
            pend_vld_d = 1'b0;
            sop_arm_d  = 1'b1;
            cnt_bits_d = '0;
            cnt_fill_d = '0;
            cnt_crc_d  = '0;
        end

        if (finish) begin
            state_d    = S_IDLE;
            blk_bits_d = cnt_bits_q;
            blk_fill_d = cnt_fill_q;
            blk_crc_d  = cnt_crc_q;
            blk_done_d = 1'b1;
        end
    end

    // A full FIFO still takes a write when the head is popped in the same cycle.
    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = ((wptr_q - rptr_q) == (AW + 1)'(FIFO_DEPTH));
        pop        = ~fifo_empty & out_ready_i;
        push       = wr_en & (~fifo_full | pop);
        ovf_d      = ovf_q | (wr_en & fifo_full & ~pop);
        wptr_d     = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            idx_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sop_arm_q  <= 1'b0;
            size_q     <= 1'b0;
            cnt_bits_q <= '0;
            cnt_fill_q <= '0;
            cnt_crc_q  <= '0;
            blk_bits_q <= '0;
            blk_fill_q <= '0;
            blk_crc_q  <= '0;
            blk_done_q <= 1'b0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sop_arm_q  <= sop_arm_d;
            size_q     <= size_d;
            cnt_bits_q <= cnt_bits_d;
            cnt_fill_q <= cnt_fill_d;
            cnt_crc_q  <= cnt_crc_d;
            blk_bits_q <= blk_bits_d;
            blk_fill_q <= blk_fill_d;
            blk_crc_q  <= blk_crc_d;
            blk_done_q <= blk_done_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wr_word;
    end

    // Head fields are gated by valid so reset forces them to zero immediately.
    assign head        = mem_q[rptr_q[AW-1:0]];
    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = fifo_empty ? 8'd0 : head[7:0];
    assign out_sop_o   = ~fifo_empty & head[9];
    assign out_eop_o   = ~fifo_empty & head[8];
    assign out_size_o  = size_q;
    assign blk_bits_o  = blk_bits_q;
    assign blk_fill_o  = blk_fill_q;
    assign blk_crc_o   = blk_crc_q;
    assign blk_done_o  = blk_done_q;
    assign overflow_o  = ovf_q;
    assign proto_err_o = perr_q;

endmodule

// File: doc/cb_output_packer.md
CB_OUTPUT_PACKER -- requirements
Module: cb_output_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of entries in the output word FIFO (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 bit_in  input  1  serial code-block bit from the segmentation data path.
REQ-005 bit_valid  input  1  bit_in is valid this cycle.
REQ-006 start  input  1  one-cycle pulse preceding the first bit of a code block.
REQ-007 filling  input  1  current valid bit is a filler bit.
REQ-008 crc  input  1  current valid bit is a code-block CRC bit.
REQ-009 stop  input  1  one-cycle pulse after the last bit of a code block.
REQ-010 block_size  input  1  sampled with start: 1 = large block, 0 = small block.
REQ-011 out_ready  input  1  downstream accepts the word at the FIFO head.
REQ-012 out_data  output  8  packed byte; first received bit in bit 7.
REQ-013 out_valid  output  1  FIFO not empty.
REQ-014 out_sop / out_eop  output  1 each  head word is first / last byte of a block.
REQ-015 out_size  output  1  block_size latched at start of the current block.
REQ-016 blk_bits / blk_fill / blk_crc  output  16 each  total, filler and CRC bit counts of the last completed block.
REQ-017 blk_done  output  1  one-cycle pulse when the blk_* counts update.
REQ-018 overflow / proto_err  output  1 each  sticky error flags.

Function
REQ-019 FSM states IDLE, COLLECT, FLUSH; reset state IDLE.
REQ-020 IDLE: start -> COLLECT; latch block_size into out_size; clear shift register, bit index, running counters; arm sop flag. Other inputs ignored.
REQ-021 COLLECT: each bit_valid shifts one bit in MSB-first; when filling=1 the stored bit is 0 regardless of bit_in.
REQ-022 COLLECT: each bit_valid increments the running total counter; filling and crc additionally increment the fill and CRC counters; all counters saturate at 16'hFFFF.
REQ-023 Eighth bit of a byte moves the assembled byte into a one-entry pending register; any previously pending byte is written to the FIFO in the same cycle with eop=0.
REQ-024 The first byte written for a block carries sop=1; all later bytes carry sop=0.
REQ-025 COLLECT: stop -> FLUSH; bit_valid in the stop cycle is ignored and sets proto_err.
REQ-026 FLUSH with partial bits (k = 1..7): cycle 1 writes the pending byte (eop=0), if present; cycle 2 writes the partial byte zero-padded in the low 8-k bits with eop=1; without a pending byte the padded byte is written in cycle 1.
REQ-027 FLUSH with no partial bits: the pending byte is written with eop=1 in one cycle; a block with zero bits writes no word.
REQ-028 On the last FLUSH cycle: blk_bits/blk_fill/blk_crc load from the running counters, blk_done pulses, state -> IDLE.
REQ-029 start in COLLECT or FLUSH sets proto_err, discards the partial and pending bytes without writing them, and restarts the block as in REQ-020.
REQ-030 FIFO write when full with no pop in the same cycle: the word is dropped and overflow is set; a write and a pop in the same cycle when full are both accepted.
REQ-031 Pop on out_valid & out_ready; the head word is presented combinationally from FIFO storage (0-cycle read latency).
REQ-032 Latency: a byte completed at cycle n with a following byte completed at cycle m is visible on out_data at m+1; the final byte is visible one cycle after its FLUSH write.
REQ-033 overflow and proto_err clear only on reset.

Reset
REQ-034 On reset assertion all outputs drive 0 asynchronously: out_data, out_valid, out_sop, out_eop, out_size, blk_bits, blk_fill, blk_crc, blk_done, overflow, proto_err.
REQ-035 On reset the FIFO empties, the pending and partial bytes are discarded, and the FSM enters IDLE; reset mid-block loses that block with no eop emitted.

Verification
REQ-036 start(block_size=0), 16 bits 0xA5,0x3C, stop, out_ready=1 -> words {A5,sop=1,eop=0},{3C,sop=0,eop=1}; blk_bits=16; blk_done pulses once.
REQ-037 start, 4 filler bits (bit_in=1), 8 data bits 1, 8 crc bits 0, stop -> words 0x0F(sop),0xF0,0x00(eop); blk_fill=4, blk_crc=8, blk_bits=20.
REQ-038 12 bits 0xFFF, stop -> 0xFF(sop,eop=0), 0xF0(eop=1); two FLUSH cycles.
REQ-039 out_ready=0, 48 bits streamed with FIFO_DEPTH=4 -> overflow=1 after the fifth write attempt; the first 4 words are intact when out_ready rises.
REQ-040 start, 5 bits, start again, 8 bits 0x81, stop -> proto_err=1; single word 0x81 with sop=1, eop=1; out_size equals the second start's block_size.
REQ-041 Reset asserted mid-COLLECT with 2 words queued -> out_valid=0 same cycle; next block packs correctly with sop on its first byte.
